decomp_dispatch: RTL and testbench
==================================

# decomp_dispatch

Parametrised packet dispatcher for the decompression path, successor to the fixed three-engine decompressor top. It decodes the mode field of each packet header beat and routes the packet to one of NUM_ENG decompression engines. It returns engine output to a single egress stream in strict packet order using an engine-ID order FIFO, so a new packet can enter one engine while an earlier packet drains from another. Invalid-mode packets and orphan beats are discarded and counted.

## Interface
- DATA_W, 64, beat width in bits
- NUM_ENG, 3, number of attached engines (1..2^SEL_W)
- SEL_W, 2, mode field width; mode = data_i[DATA_W-1 -: SEL_W] on sop beat
- ORD_DEPTH, 4, order FIFO depth in packets, power of 2, ≥2
- CNT_W, 16, status counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- data_i / valid_i / sop_i / eop_i  in  DATA_W/1/1/1  upstream beat
- ready_o  out  1  upstream ready
- data_o / valid_o / sop_o / eop_o  out  DATA_W/1/1/1  downstream beat
- ready_i  in  1  downstream ready
- eng_data_o / eng_valid_o / eng_sop_o / eng_eop_o  out  NUM_ENG*DATA_W / NUM_ENG ×3  per-engine ingress; engine k in slice k
- eng_ready_i  in  NUM_ENG  per-engine ingress ready
- eng_data_i / eng_valid_i / eng_sop_i / eng_eop_i  in  NUM_ENG*DATA_W / NUM_ENG ×3  per-engine egress
- eng_ready_o  out  NUM_ENG  per-engine egress ready
- pkt_cnt_o  out  CNT_W  accepted (dispatched) packets, saturating
- drop_cnt_o  out  CNT_W  invalid-mode packets dropped, saturating
- orphan_cnt_o  out  CNT_W  non-sop beats discarded in IDLE, saturating
- busy_o  out  1  ingress not IDLE or order FIFO not empty

## Operation
- Beat transfers when valid & ready on same edge; all handshakes are valid/ready, valid never depends on ready.
- Ingress FSM: IDLE, ROUTE, DROP. Registered sel (log2 NUM_ENG bits) holds target engine.
- IDLE, valid_i & sop_i, mode < NUM_ENG: eng_valid_o[mode]=1, ready_o = eng_ready_i[mode] & ~ord_full. On accept: push mode into order FIFO, sel←mode, pkt_cnt+1; eop_i → stay IDLE, else → ROUTE.
- IDLE, sop beat, mode ≥ NUM_ENG: ready_o=1, no engine sees it, drop_cnt+1; eop_i → IDLE, else → DROP.
- IDLE, valid_i & ~sop_i: ready_o=1, beat discarded, orphan_cnt+1.
- ROUTE: eng_valid_o[sel]=valid_i, ready_o=eng_ready_i[sel]; sop_i inside packet is forwarded unchanged (not re-decoded); accepted eop → IDLE.
- DROP: ready_o=1, beats discarded; accepted eop → IDLE.
- eng_data_o/sop/eop of every slice = data_i/sop_i/eop_i (broadcast); only eng_valid_o is steered.
- Egress: head = order FIFO head. Not empty: data_o/sop_o/eop_o = engine[head] fields, valid_o = eng_valid_i[head], eng_ready_o[head] = ready_i, all other eng_ready_o = 0. Empty: valid_o=0, all eng_ready_o=0. Accepted beat with eng_eop_i[head] pops FIFO.
- Non-head engine valid beats are held off (back-pressured), never reordered.
- Counters saturate at 2^CNT_W-1.

## Timing
- Ingress and egress data paths combinational, zero latency.
- FIFO push visible at egress the cycle after sop accept; earliest egress beat of a packet is one cycle after its sop is accepted.
- ord_full/ord_empty from registered count. Full: new sop stalled (ready_o=0) even if pop same cycle. Push+pop same cycle when not full: count unchanged.
- Pointers wrap modulo ORD_DEPTH.
- rst_n low (any cycle, incl. mid-packet): FSM→IDLE, FIFO emptied, sel=0, counters=0; ready_o, valid_o, eng_valid_o, eng_ready_o forced 0 while rst_n low; busy_o=0 first cycle after reset. Partially transferred packets are abandoned.

## Test plan
- Single-beat pkt, header mode=1, engine 1 echoes next cycle → data_o equals engine-1 beat, sop_o=eop_o=1, pkt_cnt_o=1, FIFO empty after.
- Pkt A (mode 0, 4 beats) then pkt B (mode 2, 2 beats); engine 2 answers before engine 0 → egress shows all A beats then B; eng_ready_o[2]=0 until A's eop transfers.
- Five single-beat mode-0 pkts, ready_i=0, ORD_DEPTH=4 → first four accepted, fifth sees ready_o=0 until one egress eop pops.
- Header mode=3 (NUM_ENG=3), 3 beats → ready_o=1 all beats, no eng_valid_o, drop_cnt_o=1; next valid pkt routes normally.
- Two beats without sop in IDLE → consumed, orphan_cnt_o=2, no engine activity.
- rst_n low for one cycle during beat 2 of a mode-1 pkt → next cycle busy_o=0, counters 0, a fresh sop with mode 0 routes to engine 0.

Source files
------------

// File: rtl/decomp_dispatch.sv
// Decompression packet dispatcher: routes each packet to the engine named by
// its header mode, and returns engine output in strict packet order.
module decomp_dispatch #(
  parameter int DATA_W    = 64,
  parameter int NUM_ENG   = 3,
  parameter int SEL_W     = 2,
  parameter int ORD_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      valid_i,
  input  logic                      sop_i,
  input  logic                      eop_i,
  output logic                      ready_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      valid_o,
  output logic                      sop_o,
  output logic                      eop_o,
  input  logic                      ready_i,
  output logic [NUM_ENG*DATA_W-1:0] eng_data_o,
  output logic [NUM_ENG-1:0]        eng_valid_o,
  output logic [NUM_ENG-1:0]        eng_sop_o,
  output logic [NUM_ENG-1:0]        eng_eop_o,
  input  logic [NUM_ENG-1:0]        eng_ready_i,
  input  logic [NUM_ENG*DATA_W-1:0] eng_data_i,
  input  logic [NUM_ENG-1:0]        eng_valid_i,
  input  logic [NUM_ENG-1:0]        eng_sop_i,
  input  logic [NUM_ENG-1:0]        eng_eop_i,
  output logic [NUM_ENG-1:0]        eng_ready_o,
  output logic [CNT_W-1:0]          pkt_cnt_o,
  output logic [CNT_W-1:0]          drop_cnt_o,
  output logic [CNT_W-1:0]          orphan_cnt_o,
  output logic                      busy_o
);

  localparam int IW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int AW = $clog2(ORD_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_DROP} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_sel;
  logic [IW-1:0]    r_ord [ORD_DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic [CNT_W-1:0] r_pkt;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] r_orph;

  logic [SEL_W-1:0]  w_mode;
  logic [IW-1:0]     w_mode_i;
  logic              w_mode_ok;
  logic              w_rdy;
  logic              w_hdr;
  logic              w_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [IW-1:0]     w_head;
  logic [NUM_ENG-1:0] w_ev;
  logic [DATA_W-1:0] w_ed [NUM_ENG];

  assign w_mode    = data_i[DATA_W-1 -: SEL_W];
  assign w_mode_i  = IW'(w_mode);
  assign w_mode_ok = {1'b0, w_mode} < (SEL_W+1)'(NUM_ENG);
  assign w_full    = r_cnt == (AW+1)'(ORD_DEPTH);
  assign w_empty   = r_cnt == '0;
  assign w_head    = r_ord[r_rd];

  always_comb begin
    w_rdy = 1'b0;
    w_hdr = 1'b0;
    w_ev  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          if (sop_i && w_mode_ok) begin
            w_ev[w_mode_i] = 1'b1;
            w_rdy = eng_ready_i[w_mode_i] & ~w_full;
            w_hdr = 1'b1;
          end else begin
            w_rdy = 1'b1;
          end
        end
      end
      S_ROUTE: begin
        w_ev[r_sel] = valid_i;
        w_rdy       = eng_ready_i[r_sel];
      end
      S_DROP:  w_rdy = 1'b1;
      default: w_rdy = 1'b0;
    endcase
  end

  assign w_acc  = valid_i & w_rdy;
  assign w_push = w_acc & w_hdr;
  assign w_pop  = ~w_empty & eng_valid_i[w_head] & ready_i
                & eng_eop_i[w_head];

  for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng
    assign w_ed[g] = eng_data_i[g*DATA_W +: DATA_W];
    assign eng_data_o[g*DATA_W +: DATA_W] = data_i;
    assign eng_ready_o[g] = rst_n & ~w_empty & ready_i
                          & (w_head == IW'(g));
  end

  assign eng_sop_o   = {NUM_ENG{sop_i}};
  assign eng_eop_o   = {NUM_ENG{eop_i}};
  assign eng_valid_o = {NUM_ENG{rst_n}} & w_ev;
  assign ready_o     = rst_n & w_rdy;

  assign data_o  = w_ed[w_head];
  assign sop_o   = eng_sop_i[w_head];
  assign eop_o   = eng_eop_i[w_head];
  assign valid_o = rst_n & ~w_empty & eng_valid_i[w_head];

  assign pkt_cnt_o    = r_pkt;
  assign drop_cnt_o   = r_drop;
  assign orphan_cnt_o = r_orph;
  assign busy_o       = (r_state != S_IDLE) | ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_pkt   <= '0;
      r_drop  <= '0;
      r_orph  <= '0;
    end else begin
      if (w_push) begin
        r_ord[r_wr] <= w_mode_i;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (!sop_i) begin
              if (r_orph != '1) r_orph <= r_orph + 1'b1;
            end else if (w_mode_ok) begin
              r_sel <= w_mode_i;
              if (r_pkt != '1) r_pkt <= r_pkt + 1'b1;
              if (!eop_i) r_state <= S_ROUTE;
            end else begin
              if (r_drop != '1) r_drop <= r_drop + 1'b1;
              if (!eop_i) r_state <= S_DROP;
            end
          end
        end
        S_ROUTE, S_DROP: if (w_acc && eop_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decomp_dispatch.sv
// Scoreboard bench for decomp_dispatch: expected egress beats are queued at
// ingress acceptance and checked in order as the DUT emits them.
module tb_decomp_dispatch;
  localparam int DW = 64;
  localparam int NE = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [DW-1:0]  data_i;
  logic           valid_i, sop_i, eop_i, ready_o;
  logic [DW-1:0]  data_o;
  logic           valid_o, sop_o, eop_o, ready_i;
  logic [NE*DW-1:0] eng_data_o, eng_data_i;
  logic [NE-1:0]  eng_valid_o, eng_sop_o, eng_eop_o, eng_ready_i;
  logic [NE-1:0]  eng_valid_i, eng_sop_i, eng_eop_i, eng_ready_o;
  logic [CW-1:0]  pkt_cnt_o, drop_cnt_o, orphan_cnt_o;
  logic           busy_o;

  typedef logic [DW+1:0] beat_t;
  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_pkt, exp_drop, exp_orph;

  decomp_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i),
    .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o),
    .ready_i(ready_i),
    .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
    .eng_sop_o(eng_sop_o), .eng_eop_o(eng_eop_o),
    .eng_ready_i(eng_ready_i),
    .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i),
    .eng_sop_i(eng_sop_i), .eng_eop_i(eng_eop_i),
    .eng_ready_o(eng_ready_o),
    .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o),
    .orphan_cnt_o(orphan_cnt_o), .busy_o(busy_o)
  );

  function automatic logic [DW-1:0] hdr(int m, int tag);
    logic [DW-1:0] h;
    h = 64'(tag) << 8;
    h[DW-1 -: 2] = 2'(m);
    return h;
  endfunction

  function automatic logic [DW-1:0] resp(int k, logic [DW-1:0] d);
    return d ^ {8{8'(k + 1)}};
  endfunction

  always @(negedge clk) begin
    beat_t got, want;
    if (rst_n && valid_o && ready_i) begin
      got = {data_o, sop_o, eop_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL egress_extra: got %h, expected no beat", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL egress_order: got %h, expected %h", got, want);
        end
      end
    end
  end

  task automatic send(input int k, input logic [DW-1:0] d,
                      input logic s, input logic e,
                      input bit push, output bit ok);
    data_i = d; sop_i = s; eop_i = e; valid_i = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; break; end
    end
    if (ok && push) sb.push_back({resp(k, d), s, e});
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic up_pkt(input int k, input logic [DW-1:0] h,
                        input int nb, output bit ok);
    bit b;
    ok = 1'b1;
    for (int j = 0; j < nb; j++) begin
      send(k, h + 64'(j), j == 0, j == nb - 1, 1'b1, b);
      ok &= b;
    end
  endtask

  task automatic eng_send(input int k, input logic [DW-1:0] d,
                          input logic s, input logic e,
                          output int waited, output bit ok);
    eng_data_i[k*DW +: DW] = d;
    eng_sop_i[k] = s; eng_eop_i[k] = e; eng_valid_i[k] = 1'b1;
    ok = 1'b0; waited = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (eng_ready_o[k]) begin ok = 1'b1; waited = n; break; end
    end
    @(posedge clk); #1;
    eng_valid_i[k] = 1'b0;
  endtask

  task automatic eng_pkt(input int k, input logic [DW-1:0] h,
                         input int nb, output bit ok);
    bit b;
    int w;
    ok = 1'b1;
    for (int j = 0; j < nb; j++) begin
      eng_send(k, resp(k, h + 64'(j)), j == 0, j == nb - 1, w, b);
      ok &= b;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready_i = 1'b1; eng_ready_i = '1;
    data_i = hdr(0, 1); valid_i = 1'b1; sop_i = 1'b1; eop_i = 1'b1;
    eng_data_i = '0; eng_valid_i = '1; eng_sop_i = '1; eng_eop_i = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++;
      $display("FAIL rst_ready: got %b, expected 0", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b, expected 0", valid_o); end
    checks++;
    if (eng_valid_o !== '0 || eng_ready_o !== '0) begin errors++;
      $display("FAIL rst_eng: got v=%b r=%b, expected 0/0",
               eng_valid_o, eng_ready_o); end
    @(posedge clk); #1;
    rst_n = 1'b1; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    eng_valid_i = '0; eng_sop_i = '0; eng_eop_i = '0;
    exp_pkt = 0; exp_drop = 0; exp_orph = 0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || pkt_cnt_o !== '0 || drop_cnt_o !== '0
        || orphan_cnt_o !== '0) begin errors++;
      $display("FAIL rst_state: got busy=%b cnt=%0d/%0d/%0d, expected 0",
               busy_o, pkt_cnt_o, drop_cnt_o, orphan_cnt_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    int w;
    bit ok;
    d = hdr(1, 5) | 64'h33;
    data_i = d; sop_i = 1'b1; eop_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_valid_o !== 3'b010 || ready_o !== 1'b1) begin errors++;
      $display("FAIL single_steer: got v=%b r=%b, expected 010/1",
               eng_valid_o, ready_o); end
    checks++;
    if (eng_data_o[1*DW +: DW] !== d || eng_sop_o !== 3'b111) begin
      errors++;
      $display("FAIL single_bcast: got %h, expected %h",
               eng_data_o[1*DW +: DW], d); end
    sb.push_back({resp(1, d), 1'b1, 1'b1});
    @(posedge clk); #1;
    valid_i = 1'b0; exp_pkt++;
    checks++;
    if (pkt_cnt_o !== CW'(exp_pkt) || busy_o !== 1'b1) begin errors++;
      $display("FAIL single_cnt: got %0d busy=%b, expected %0d busy=1",
               pkt_cnt_o, busy_o, exp_pkt); end
    eng_send(1, resp(1, d), 1'b1, 1'b1, w, ok);
    checks++;
    if (!ok || w != 0) begin errors++;
      $display("FAIL single_latency: got wait=%0d ok=%b, expected 0/1",
               w, ok); end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++;
      $display("FAIL single_empty: got busy=%b, expected 0", busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ha, hb;
    bit oka, okb, ok0, ok2, bad, done0;
    int n;
    ha = hdr(0, 10); hb = hdr(2, 20);
    up_pkt(0, ha, 4, oka);
    up_pkt(2, hb, 2, okb);
    exp_pkt += 2;
    checks++;
    if (!oka || !okb) begin errors++;
      $display("FAIL order_ingress: got ok=%b%b, expected 11", oka, okb); end
    bad = 1'b0; done0 = 1'b0; n = 0;
    fork
      eng_pkt(2, hb, 2, ok2);
      begin
        repeat (2) @(posedge clk); #1;
        eng_pkt(0, ha, 4, ok0);
        done0 = 1'b1;
      end
      while (!done0 && n < 200) begin
        @(negedge clk);
        n++;
        if (!done0 && eng_ready_o[2]) bad = 1'b1;
      end
    join
    checks++;
    if (bad || !ok0 || !ok2) begin errors++;
      $display("FAIL order_holdoff: got bad=%b ok=%b%b, expected 0/11",
               bad, ok0, ok2); end
    checks++;
    if (sb.size() != 0 || pkt_cnt_o !== CW'(exp_pkt)) begin errors++;
      $display("FAIL order_drain: got left=%0d cnt=%0d, expected 0/%0d",
               sb.size(), pkt_cnt_o, exp_pkt); end
  endtask

  task automatic test_full();
    bit ok, ok5, b, bad;
    int w;
    ready_i = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(0, hdr(0, 40 + i), 1'b1, 1'b1, 1'b1, b);
      ok &= b;
    end
    exp_pkt += 4;
    checks++;
    if (!ok) begin errors++;
      $display("FAIL full_first4: got ok=%b, expected 1", ok); end
    bad = 1'b0;
    fork
      send(0, hdr(0, 44), 1'b1, 1'b1, 1'b1, ok5);
      begin
        repeat (3) begin
          @(negedge clk);
          if (ready_o) bad = 1'b1;
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        eng_send(0, resp(0, hdr(0, 40)), 1'b1, 1'b1, w, b);
        if (!b) bad = 1'b1;
      end
    join
    exp_pkt++;
    checks++;
    if (bad || !ok5) begin errors++;
      $display("FAIL full_stall: got bad=%b ok5=%b, expected 0/1",
               bad, ok5); end
    ok = 1'b1;
    for (int i = 1; i < 5; i++) begin
      eng_send(0, resp(0, hdr(0, 40 + i)), 1'b1, 1'b1, w, b);
      ok &= b;
    end
    checks++;
    if (!ok || sb.size() != 0 || pkt_cnt_o !== CW'(exp_pkt)) begin
      errors++;
      $display("FAIL full_drain: got ok=%b left=%0d cnt=%0d, expected 1/0/%0d",
               ok, sb.size(), pkt_cnt_o, exp_pkt); end
  endtask

  task automatic test_drop();
    bit bad, ok;
    int w;
    bad = 1'b0;
    for (int j = 0; j < 3; j++) begin
      data_i = hdr(3, 60) + 64'(j);
      sop_i = (j == 0); eop_i = (j == 2); valid_i = 1'b1;
      @(negedge clk);
      if (ready_o !== 1'b1 || eng_valid_o !== '0) bad = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0; exp_drop++;
    checks++;
    if (bad) begin errors++;
      $display("FAIL drop_beats: got bad=1, expected ready=1 no eng valid");
    end
    checks++;
    if (drop_cnt_o !== CW'(exp_drop) || busy_o !== 1'b0) begin errors++;
      $display("FAIL drop_cnt: got %0d busy=%b, expected %0d busy=0",
               drop_cnt_o, busy_o, exp_drop); end
    send(2, hdr(2, 61), 1'b1, 1'b1, 1'b1, ok);
    exp_pkt++;
    eng_send(2, resp(2, hdr(2, 61)), 1'b1, 1'b1, w, ok);
    checks++;
    if (!ok || pkt_cnt_o !== CW'(exp_pkt) || sb.size() != 0) begin
      errors++;
      $display("FAIL drop_next: got ok=%b cnt=%0d, expected 1/%0d",
               ok, pkt_cnt_o, exp_pkt); end
  endtask

  task automatic test_orphan();
    bit bad;
    bad = 1'b0;
    for (int j = 0; j < 2; j++) begin
      data_i = hdr(1, 70 + j); sop_i = 1'b0; eop_i = j[0];
      valid_i = 1'b1;
      @(negedge clk);
      if (ready_o !== 1'b1 || eng_valid_o !== '0) bad = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0; exp_orph += 2;
    checks++;
    if (bad || orphan_cnt_o !== CW'(exp_orph)
        || pkt_cnt_o !== CW'(exp_pkt)) begin errors++;
      $display("FAIL orphan: got bad=%b orph=%0d pkt=%0d, expected 0/%0d/%0d",
               bad, orphan_cnt_o, pkt_cnt_o, exp_orph, exp_pkt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w;
    send(1, hdr(1, 80), 1'b1, 1'b0, 1'b0, ok);
    data_i = hdr(1, 80) + 64'd1; sop_i = 1'b0; eop_i = 1'b0;
    valid_i = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || eng_valid_o !== '0) begin errors++;
      $display("FAIL mid_gate: got r=%b v=%b, expected 0/000",
               ready_o, eng_valid_o); end
    @(posedge clk); #1;
    rst_n = 1'b1; valid_i = 1'b0;
    exp_pkt = 0; exp_drop = 0; exp_orph = 0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || pkt_cnt_o !== '0 || drop_cnt_o !== '0
        || orphan_cnt_o !== '0) begin errors++;
      $display("FAIL mid_state: got busy=%b cnt=%0d/%0d/%0d, expected 0",
               busy_o, pkt_cnt_o, drop_cnt_o, orphan_cnt_o); end
    @(posedge clk); #1;
    data_i = hdr(0, 90); sop_i = 1'b1; eop_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_valid_o !== 3'b001 || ready_o !== 1'b1) begin errors++;
      $display("FAIL mid_route: got v=%b r=%b, expected 001/1",
               eng_valid_o, ready_o); end
    sb.push_back({resp(0, hdr(0, 90)), 1'b1, 1'b1});
    @(posedge clk); #1;
    valid_i = 1'b0; exp_pkt++;
    eng_send(0, resp(0, hdr(0, 90)), 1'b1, 1'b1, w, ok);
    checks++;
    if (!ok || pkt_cnt_o !== CW'(exp_pkt) || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got ok=%b cnt=%0d busy=%b, expected 1/%0d/0",
               ok, pkt_cnt_o, busy_o, exp_pkt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_drop();
    test_orphan();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin errors++;
      $display("FAIL sb_left: got %0d beats, expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
